// File: rtl/dma_reg_burst_writer.sv
// Burst sequencer: writes a stream of words into consecutive register-file entries.
// Optional free-running write counter output enabled by BURST_WORD_COUNTER_EN.
module dma_reg_burst_writer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  base_idx,
    input  logic [5:0]        length,
    input  logic              abort,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [IDX_W-1:0]  sel_mux,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
`ifdef BURST_WORD_COUNTER_EN
    ,
    output logic [15:0]       word_count
`endif
);

    localparam int unsigned REM_W   = 6;
    localparam int unsigned MAX_LEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [REM_W-1:0]   rem, rem_d;
    logic [IDX_W-1:0]   sel_d;
    logic [DATA_W-1:0]  wr_data_d;
    logic               wr_en_d;
    logic               done_d;
    logic               beat;

    assign busy = (state != IDLE);

    // Next-state, counters and next values of the registered write port.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        rem_d      = rem;
        sel_d      = sel_mux;
        wr_data_d  = wr_data;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        data_ready = 1'b0;
        beat       = 1'b0;
        case (state)
            IDLE: begin
                if (start && (length != '0)) begin
                    idx_d   = base_idx;
                    rem_d   = (length > REM_W'(MAX_LEN)) ? REM_W'(MAX_LEN) : length;
                    state_d = XFER;
                end
            end
            XFER: begin
                data_ready = !abort;
                beat       = data_valid && !abort;
                if (abort) begin
                    state_d = IDLE;
                end else if (beat) begin
                    sel_d     = idx;
                    wr_data_d = data_in;
                    wr_en_d   = 1'b1;
                    idx_d     = idx + 1'b1;
                    rem_d     = rem - 1'b1;
                    // Final word: done lines up with its write strobe.
                    if (rem == REM_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            rem     <= '0;
            sel_mux <= '0;
            wr_data <= '0;
            wr_en   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            rem     <= rem_d;
            sel_mux <= sel_d;
            wr_data <= wr_data_d;
            wr_en   <= wr_en_d;
            done    <= done_d;
        end
    end

`ifdef BURST_WORD_COUNTER_EN
    // Counts issued write strobes; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
        end else if (wr_en) begin
            word_count <= word_count + 16'd1;
        end
    end
`endif

endmodule
